// File: rtl/fifo_status.sv
// fifo_status: synchronous show-ahead FIFO with occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags. A push at full is accepted when a pop is
// accepted in the same cycle. Every output is derived from registered
// state; pop_data is a read of the memory at the registered read pointer.
module fifo_status #(
    parameter int DATA_BITS     = 8,
    parameter int ADDR_BITS     = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 clr_err,
    input  logic                 push_en,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop_en,
    output logic [DATA_BITS-1:0] pop_data,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    underflow
);

    localparam int                 DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C   = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AFULL_C   = (ADDR_BITS+1)'(AFULL_THRESH);
    localparam logic [ADDR_BITS:0] AEMPTY_C  = (ADDR_BITS+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_BITS:0] CNT_ZERO  = (ADDR_BITS+1)'(0);
    localparam logic [ADDR_BITS:0] CNT_ONE   = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ZERO = ADDR_BITS'(0);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);
    // almost_full out of reset is only set for a zero threshold (count 0 >= 0)
    localparam logic AFULL_RST = (AFULL_THRESH == 0) ? 1'b1 : 1'b0;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 almost_full_q, almost_full_d;
    logic                 almost_empty_q, almost_empty_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    logic                 pop_acc_s;
    logic                 push_acc_s;
    logic                 ovf_evt_s;
    logic                 unf_evt_s;
    logic                 wr_en_s;

    // Accept decisions: a pop needs data; a push needs room, or a concurrent pop
    always_comb begin
        pop_acc_s  = pop_en & ~empty_q;
        push_acc_s = push_en & (~full_q | pop_acc_s);
        // flush swallows push/pop, so it raises no error either
        if (flush) begin
            ovf_evt_s = 1'b0;
            unf_evt_s = 1'b0;
            wr_en_s   = 1'b0;
        end else begin
            ovf_evt_s = push_en & ~push_acc_s;
            unf_evt_s = pop_en & ~pop_acc_s;
            wr_en_s   = push_acc_s & ~reset;
        end
    end

    // Next-state for pointers, occupancy, status flags and sticky errors
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = PTR_ZERO;
            wr_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (push_acc_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_acc_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_acc_s, pop_acc_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        full_d         = (count_d == DEPTH_C);
        empty_d        = (count_d == CNT_ZERO);
        almost_full_d  = (count_d >= AFULL_C);
        almost_empty_d = (count_d <= AEMPTY_C);

        // a fresh error in the clearing cycle keeps the flag set
        overflow_d  = ovf_evt_s | (overflow_q  & ~clr_err);
        underflow_d = unf_evt_s | (underflow_q & ~clr_err);
    end

    // State register with synchronous reset; reset outranks flush and traffic
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q       <= PTR_ZERO;
            wr_ptr_q       <= PTR_ZERO;
            count_q        <= CNT_ZERO;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= AFULL_RST;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // Storage array write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data     = mem[rd_ptr_q];
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_status.sv
// tb_fifo_status: directed and random traffic against a queue-based
// reference model. The stimulus process pushes the expected post-edge
// state into a scoreboard; the monitor pops and compares at each negedge.
module tb_fifo_status;

    localparam int DW     = 8;
    localparam int AW     = 3;
    localparam int DEPTH  = 8;
    localparam int AF_TH  = 6;
    localparam int AE_TH  = 2;

    logic          clk;
    logic          reset, flush, clr_err, push_en, pop_en;
    logic [DW-1:0] push_data, pop_data;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   count;

    typedef struct {
        int       cnt;
        bit [7:0] head;
        bit       ful, emp, af, ae, ov, un;
    } exp_t;

    exp_t     exp_q[$];
    bit [7:0] model_q[$];
    bit       m_ov, m_un;
    int       checks, errors;

    fifo_status #(
        .DATA_BITS(DW), .ADDR_BITS(AW),
        .AFULL_THRESH(AF_TH), .AEMPTY_THRESH(AE_TH)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .clr_err(clr_err),
        .push_en(push_en), .push_data(push_data), .pop_en(pop_en),
        .pop_data(pop_data), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, queue expectation
    task automatic step(input bit rs, input bit fl, input bit ce,
                        input bit pu, input bit [7:0] d, input bit po);
        exp_t e;
        bit pop_ok, push_ok;
        reset = rs; flush = fl; clr_err = ce;
        push_en = pu; push_data = d; pop_en = po;
        if (rs) begin
            model_q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else if (fl) begin
            model_q.delete();
            if (ce) begin
                m_ov = 1'b0;
                m_un = 1'b0;
            end
        end else begin
            pop_ok  = po && (model_q.size() > 0);
            push_ok = pu && ((model_q.size() < DEPTH) || pop_ok);
            if (pop_ok)  void'(model_q.pop_front());
            if (push_ok) model_q.push_back(d);
            m_ov = (pu && !push_ok) || (m_ov && !ce);
            m_un = (po && !pop_ok)  || (m_un && !ce);
        end
        e.cnt  = model_q.size();
        e.head = (model_q.size() > 0) ? model_q[0] : 8'h00;
        e.ful  = (e.cnt == DEPTH);
        e.emp  = (e.cnt == 0);
        e.af   = (e.cnt >= AF_TH);
        e.ae   = (e.cnt <= AE_TH);
        e.ov   = m_ov;
        e.un   = m_un;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit [7:0] d);
        step(1'b0, 1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Monitor: compare the DUT state after each edge against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("count",        32'(count),        32'(e.cnt));
            chk("full",         32'(full),         32'(e.ful));
            chk("empty",        32'(empty),        32'(e.emp));
            chk("almost_full",  32'(almost_full),  32'(e.af));
            chk("almost_empty", 32'(almost_empty), 32'(e.ae));
            chk("overflow",     32'(overflow),     32'(e.ov));
            chk("underflow",    32'(underflow),    32'(e.un));
            if (!e.emp) chk("pop_data", 32'(pop_data), 32'(e.head));
        end
    end

    initial begin
        bit rs, fl, ce, pu, po;
        checks = 0; errors = 0;
        m_ov = 1'b0; m_un = 1'b0;
        reset = 1'b1; flush = 1'b0; clr_err = 1'b0;
        push_en = 1'b0; pop_en = 1'b0; push_data = 8'h00;

        // 1: reset, three pushes, three pops back to empty
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        push(8'h11); push(8'h22); push(8'h33);
        pop(); pop(); pop(); idle();

        // 2: fill to full, rejected 9th push, drain all eight
        for (int i = 0; i < 8; i++) push(8'(i));
        push(8'hAA);
        for (int i = 0; i < 8; i++) pop();

        // 3: clear errors, fill, push+pop at full, drain
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 8; i++) pop();

        // 4: wrap-around with 20 simultaneous push/pop at count 3
        push(8'hA0); push(8'hA1); push(8'hA2);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'hB0 + i), 1'b1);
        pop(); pop(); pop();

        // 5: underflow, clear, clear colliding with a new underflow
        pop(); idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        idle();
        pop();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        idle();

        // 6: flush with push at count 5 keeps errors, then reset with push
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hEE, 1'b0);
        idle();
        for (int i = 0; i < 5; i++) push(8'(8'hD0 + i));
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hEF, 1'b1);
        idle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 99) == 0);
            fl = ($urandom_range(0, 49) == 0);
            ce = fl ? 1'b0 : ($urandom_range(0, 19) == 0);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 50);
            step(rs, fl, ce, pu, 8'($urandom), po);
        end
        idle();

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
